// File: rtl/top.sv
// 8N1 UART endpoint: independent transmitter and receiver sharing one clock
// and one baud rate, suitable for tx->rx loopback self-test.
module top #(
    parameter int CLK_FREQ = 1000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] txin,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rxout,
    output logic       rxdone,
    output logic       txdone
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_MID  = CW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t        r_tx_state;
    state_t        w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sh;
    logic          r_txdone;
    logic          w_tx;
    logic          w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        unique case (r_tx_state)
            S_IDLE: begin
                if (start) w_tx_next = S_START;
            end
            S_START: begin
                if (w_tx_tick) w_tx_next = S_DATA;
            end
            S_DATA: begin
                if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
            end
            S_STOP: begin
                if (w_tx_tick) w_tx_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx = 1'b1;
        unique case (r_tx_state)
            S_IDLE:  w_tx = 1'b1;
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_tx_sh[0];
            S_STOP:  w_tx = 1'b1;
        endcase
    end

    // Word is captured only on the IDLE->START edge, so txin is free
    // to change during a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_txdone <= 1'b0;
        end else begin
            r_txdone <= (r_tx_state == S_STOP) && w_tx_tick;
            if (r_tx_state == S_IDLE) begin
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
                if (start) r_tx_sh <= txin;
            end else if (w_tx_tick) begin
                r_tx_cnt <= '0;
                if (r_tx_state == S_DATA) begin
                    r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    assign tx     = w_tx;
    assign txdone = r_txdone;

    // ---------------- receiver ----------------
    logic          r_rx_meta;
    logic          r_rx_sync;
    state_t        r_rx_state;
    state_t        w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic [7:0]    r_rxout;
    logic          r_rxdone;
    logic          r_ferr;
    logic          w_rx_tick;
    logic          w_rx_mid;
    logic          w_rx_shift;
    logic          w_rx_load;
    logic          w_rx_ferr;

    assign w_rx_tick = (r_rx_cnt == C_LAST);
    assign w_rx_mid  = (r_rx_cnt == C_MID);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // After a bad stop bit, STOP is held until the line idles high again.
    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            S_IDLE: begin
                if (!r_rx_sync) w_rx_next = S_START;
            end
            S_START: begin
                if (w_rx_mid) w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
            end
            S_STOP: begin
                if (r_ferr) begin
                    if (r_rx_sync) w_rx_next = S_IDLE;
                end else if (w_rx_tick && r_rx_sync) begin
                    w_rx_next = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_rx_shift = 1'b0;
        w_rx_load  = 1'b0;
        w_rx_ferr  = 1'b0;
        unique case (r_rx_state)
            S_IDLE:  w_rx_shift = 1'b0;
            S_START: w_rx_shift = 1'b0;
            S_DATA:  w_rx_shift = w_rx_tick;
            S_STOP: begin
                w_rx_load = !r_ferr && w_rx_tick && r_rx_sync;
                w_rx_ferr = !r_ferr && w_rx_tick && !r_rx_sync;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_rxout  <= '0;
            r_rxdone <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_rxdone <= w_rx_load;
            if (w_rx_load) r_rxout <= r_rx_sh;
            if (w_rx_ferr) r_ferr <= 1'b1;
            if (w_rx_shift) begin
                r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (r_rx_state == S_IDLE) begin
                r_rx_cnt <= '0;
                r_rx_bit <= '0;
                r_ferr   <= 1'b0;
            end else if (r_rx_state == S_START && w_rx_mid) begin
                r_rx_cnt <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
        end
    end

    assign rxout  = r_rxout;
    assign rxdone = r_rxdone;

endmodule

// File: tb/tb_top.sv
// Directed bench for the loopback UART: scoreboard of sent bytes checked
// against every rxdone, plus frame timing, framing error, glitch and reset.
module tb_top;

    localparam int CPB   = 104;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] txin;
    logic       tx;
    logic       rx;
    logic [7:0] rxout;
    logic       rxdone;
    logic       txdone;
    logic       loop;
    logic       rx_drv;

    int errors = 0;
    int checks = 0;
    int n_rxdone = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    logic prev_rxdone = 1'b0;
    logic prev_txdone = 1'b0;
    logic [7:0] sb[$];

    assign rx = loop ? tx : rx_drv;

    top dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .txin   (txin),
        .tx     (tx),
        .rx     (rx),
        .rxout  (rxout),
        .rxdone (rxdone),
        .txdone (txdone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and pulse-width monitor.
    always @(negedge clk) begin
        if (rxdone) begin
            n_rxdone++;
            last_rx_cyc = cyc;
            chk("rxdone_width", {31'd0, prev_rxdone}, 32'd0);
            chk("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) chk("rxout_sb", {24'd0, rxout}, {24'd0, sb.pop_front()});
        end
        if (txdone) chk("txdone_width", {31'd0, prev_txdone}, 32'd0);
        prev_rxdone = rxdone;
        prev_txdone = txdone;
    end

    task automatic send_frame(input logic [7:0] b, input bit chk_bits,
                              output int len);
        logic [9:0] pat;
        int gap;
        pat = {1'b1, b, 1'b0};
        len = -1;
        txin = b;
        start = 1'b1;
        sb.push_back(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < FRAME + 200; k++) begin
            if (chk_bits && k < FRAME && (k % CPB) == CPB / 2)
                chk($sformatf("txbit%0d", k / CPB), {31'd0, tx},
                    {31'd0, pat[k / CPB]});
            if (txdone) begin
                len = k;
                gap = cyc - last_rx_cyc;
                chk("rx_before_tx", {31'd0, (gap >= 45 && gap <= 60)}, 32'd1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_txdone(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < FRAME + 200; k++) begin
            @(negedge clk);
            if (txdone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] pat;
        pat = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = pat[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int len;
        int len0;
        int len1;
        int lowcnt;
        int base;
        int n_tx;
        int tdc;
        bit ok;
        logic [7:0] v;

        rst = 1'b1;
        start = 1'b0;
        txin = 8'h00;
        loop = 1'b1;
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rxout", {24'd0, rxout}, 32'd0);
        chk("rst_rxdone", {31'd0, rxdone}, 32'd0);
        chk("rst_txdone", {31'd0, txdone}, 32'd0);
        rst = 1'b0;

        lowcnt = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) lowcnt++;
        end
        chk("idle_tx_low", lowcnt, 0);

        send_frame(8'hA5, 1'b1, len);
        chk("a5_len", len, FRAME);
        chk("a5_rxout", {24'd0, rxout}, 32'h A5);
        repeat (20) @(negedge clk);

        // Back-to-back: start held, new word written on each txdone.
        base = n_rxdone;
        n_tx = 0;
        v = 8'($urandom_range(200, 10));
        txin = v;
        sb.push_back(v);
        start = 1'b1;
        while (n_tx < 10) begin
            wait_txdone(ok);
            chk("b2b_txdone_seen", {31'd0, ok}, 32'd1);
            if (!ok) break;
            n_tx++;
            chk("b2b_rx_first", n_rxdone, base + n_tx);
            if (n_tx < 10) begin
                v = 8'($urandom_range(200, 10));
                txin = v;
                sb.push_back(v);
                @(negedge clk);
                chk("b2b_gap", {31'd0, tx}, 32'd0);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (200) @(negedge clk);
        chk("b2b_sb_empty", sb.size(), 0);

        send_frame(8'h00, 1'b0, len0);
        chk("rxout_00", {24'd0, rxout}, 32'h00);
        repeat (20) @(negedge clk);
        send_frame(8'hFF, 1'b0, len1);
        chk("rxout_ff", {24'd0, rxout}, 32'hFF);
        chk("len_00", len0, FRAME);
        chk("len_ff_eq_00", len1, len0);
        repeat (20) @(negedge clk);

        // Framing error then a good frame, driven externally.
        loop = 1'b0;
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        base = n_rxdone;
        drive_rx(8'h3C, 1'b0);
        repeat (300) @(negedge clk);
        chk("ferr_no_rxdone", n_rxdone, base);
        chk("ferr_rxout_kept", {24'd0, rxout}, 32'hFF);
        sb.push_back(8'h5A);
        drive_rx(8'h5A, 1'b1);
        repeat (300) @(negedge clk);
        chk("good_rxdone", n_rxdone, base + 1);
        chk("good_rxout", {24'd0, rxout}, 32'h5A);

        base = n_rxdone;
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_no_rxdone", n_rxdone, base);
        chk("glitch_rxout", {24'd0, rxout}, 32'h5A);

        // Reset in the middle of a transmit frame.
        loop = 1'b1;
        base = n_rxdone;
        txin = 8'h77;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        tdc = 0;
        repeat (1500) begin
            @(negedge clk);
            if (txdone) tdc++;
        end
        chk("midrst_no_txdone", tdc, 0);
        chk("midrst_no_rxdone", n_rxdone, base);
        chk("midrst_rxout", {24'd0, rxout}, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
